player_bullet: RTL and testbench

Player projectile engine. Sits directly downstream of `player`:
- consumes the debounced centre button and `player`'s `alive_o`/`pos_left_o`;
- launches one bullet from the ship's centre and steps it upward once per frame;
- retires the bullet at the top border or on a collision report.

Outputs feed the VGA compositor and the enemy-grid collision checker.

---
 rtl/player_bullet_pkg.sv | 25 ++
 rtl/player_bullet_counter.sv | 25 ++
 rtl/player_bullet.sv | 144 ++++++++++++++
 tb/tb_player_bullet.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/player_bullet_pkg.sv
// Shared definitions for the player projectile engine: state encoding, ship
// geometry and screen borders common with the player module.
package player_bullet_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    FLYING   = 3'b010,
    COOLDOWN = 3'b100
  } state_e;

  localparam int unsigned PLAYER_WIDTH      = 35;
  localparam int unsigned PLAYER_CENTER_OFS = 17;
  localparam int unsigned BULLET_WIDTH      = 2;
  localparam int unsigned BULLET_HEIGHT     = 8;

  localparam logic [9:0] SCREEN_LEFT   = 10'd0;
  localparam logic [9:0] SCREEN_RIGHT  = 10'd639;
  localparam logic [9:0] SCREEN_TOP    = 10'd0;
  localparam logic [9:0] SCREEN_BOTTOM = 10'd479;

  function automatic logic [9:0] bullet_spawn_x(input logic [9:0] pos_left);
    return pos_left + 10'(PLAYER_CENTER_OFS);
  endfunction

endpackage

// File: rtl/player_bullet_counter.sv
// Generic up-counter with synchronous reset to a configurable value and an
// increment enable; used by the bullet engine for its cooldown count.
module counter #(
  parameter int unsigned           width_p     = 4,
  parameter logic [width_p-1:0]    reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= reset_val_p;
    end else if (en_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/player_bullet.sv
// Player projectile engine: launches one bullet from the ship centre, moves it
// up once per frame, retires it at the top border or on collision.
// Optional post-retirement cooldown enabled by PLAYER_BULLET_COOLDOWN_EN.
module player_bullet
  import player_bullet_pkg::*;
#(
  parameter logic [11:0] color_p      = 12'b0000_1111_0000,
  parameter logic [9:0]  speed_p      = 10'd4,
  parameter logic [9:0]  spawn_y_p    = 10'd440,
  parameter logic [9:0]  top_border_p = 10'd8,
  parameter logic [3:0]  cooldown_p   = 4'd8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic       shoot_i,
  input  logic       alive_i,
  input  logic       freeze_i,
  input  logic [9:0] pos_left_i,
  input  logic       collide_i,
  output logic       active_o,
  output logic       fired_o,
  output logic [9:0] bullet_x_o,
  output logic [9:0] bullet_y_o,
  output logic [3:0] bullet_red_o,
  output logic [3:0] bullet_green_o,
  output logic [3:0] bullet_blue_o
);

  localparam logic [9:0] TOP_LIMIT = top_border_p + speed_p;

  state_e     r_state;
  logic       r_shoot_q;
  logic       r_active;
  logic       r_fired;
  logic [9:0] r_x;
  logic [9:0] r_y;

  logic w_launch;
  logic w_cancel;
  logic w_at_top;
  logic w_step;
  logic w_leave;

  // Border test precedes the subtract, so y can never wrap below zero.
  always_comb begin
    w_launch = 1'b0;
    w_cancel = 1'b0;
    w_at_top = 1'b0;
    w_step   = 1'b0;
    if (r_state == IDLE) begin
      w_launch = shoot_i & ~r_shoot_q & alive_i & ~freeze_i;
    end
    if (r_state == FLYING) begin
      w_cancel = ~alive_i | collide_i;
      if (!w_cancel && !freeze_i && frame_tick_i) begin
        w_at_top = (r_y < TOP_LIMIT);
        w_step   = ~w_at_top;
      end
    end
    w_leave = w_cancel | w_at_top;
  end

`ifdef PLAYER_BULLET_COOLDOWN_EN
  logic [3:0] w_cd_count;
  logic       w_cd_en;
  logic       w_cd_done;
  logic       w_cd_reset;

  assign w_cd_done  = (r_state == COOLDOWN) && (w_cd_count == cooldown_p);
  assign w_cd_en    = (r_state == COOLDOWN) & frame_tick_i & ~freeze_i & ~w_cd_done;
  assign w_cd_reset = reset_i | w_leave;

  counter #(
    .width_p     (4),
    .reset_val_p (4'd0)
  ) u_cooldown_cnt (
    .clk_i   (clk_i),
    .reset_i (w_cd_reset),
    .en_i    (w_cd_en),
    .count_o (w_cd_count)
  );

  localparam state_e RETIRE_STATE = COOLDOWN;
`else
  logic w_unused_cooldown;
  assign w_unused_cooldown = ^cooldown_p;

  localparam state_e RETIRE_STATE = IDLE;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_shoot_q <= 1'b0;
      r_active  <= 1'b0;
      r_fired   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_shoot_q <= shoot_i;
      r_fired   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state  <= FLYING;
            r_active <= 1'b1;
            r_fired  <= 1'b1;
            r_x      <= bullet_spawn_x(pos_left_i);
            r_y      <= spawn_y_p;
          end
        end
        FLYING: begin
          if (w_leave) begin
            r_state  <= RETIRE_STATE;
            r_active <= 1'b0;
          end else if (w_step) begin
            r_y <= r_y - speed_p;
          end
        end
`ifdef PLAYER_BULLET_COOLDOWN_EN
        COOLDOWN: begin
          if (w_cd_done) begin
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign active_o       = r_active;
  assign fired_o        = r_fired;
  assign bullet_x_o     = r_x;
  assign bullet_y_o     = r_y;
  assign bullet_red_o   = color_p[11:8];
  assign bullet_green_o = color_p[7:4];
  assign bullet_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: launch/retire events are queued by the
// stimulus and checked by an independent monitor; state spot checks inline.
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_i, frame_tick_i, shoot_i, alive_i, freeze_i, collide_i;
  logic [9:0] pos_left_i;
  logic       active_o, fired_o;
  logic [9:0] bullet_x_o, bullet_y_o;
  logic [3:0] bullet_red_o, bullet_green_o, bullet_blue_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    bit         is_launch;
    logic [9:0] x;
    logic [9:0] y;
  } ev_t;
  ev_t exp_q[$];

  player_bullet #(
    .color_p      (12'b0000_1111_0000),
    .speed_p      (10'd4),
    .spawn_y_p    (10'd440),
    .top_border_p (10'd8),
    .cooldown_p   (4'd8)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .frame_tick_i   (frame_tick_i),
    .shoot_i        (shoot_i),
    .alive_i        (alive_i),
    .freeze_i       (freeze_i),
    .pos_left_i     (pos_left_i),
    .collide_i      (collide_i),
    .active_o       (active_o),
    .fired_o        (fired_o),
    .bullet_x_o     (bullet_x_o),
    .bullet_y_o     (bullet_y_o),
    .bullet_red_o   (bullet_red_o),
    .bullet_green_o (bullet_green_o),
    .bullet_blue_o  (bullet_blue_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    cyc();
    frame_tick_i = 1'b0;
    cyc();
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit launch, input logic [9:0] x, input logic [9:0] y);
    ev_t e;
    e.is_launch = launch;
    e.x = x;
    e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input bit launch);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: x=%0d y=%0d with no event expected",
               launch ? "launch" : "retire", bullet_x_o, bullet_y_o);
    end else begin
      e = exp_q.pop_front();
      if (e.is_launch != launch || bullet_x_o !== e.x || bullet_y_o !== e.y ||
          (launch && active_o !== 1'b1)) begin
        bad++;
        $display("FAIL event: got launch=%0d x=%0d y=%0d act=%0d expected launch=%0d x=%0d y=%0d",
                 launch, bullet_x_o, bullet_y_o, active_o, e.is_launch, e.x, e.y);
      end
    end
  endtask

  logic prev_active = 1'b0;
  always @(negedge clk_i) begin
    if (reset_i === 1'b0) begin
      if (fired_o === 1'b1) check_ev(1'b1);
      if (prev_active === 1'b1 && active_o === 1'b0) check_ev(1'b0);
    end
    prev_active = active_o;
  end

  initial begin
    reset_i = 1'b1; frame_tick_i = 1'b0; shoot_i = 1'b0; alive_i = 1'b1;
    freeze_i = 1'b0; collide_i = 1'b0; pos_left_i = 10'd250;
    repeat (3) cyc();
    reset_i = 1'b0;
    cyc();
    chk("reset_active", 12'(active_o), 12'd0);
    chk("reset_fired", 12'(fired_o), 12'd0);
    chk("reset_x", 12'(bullet_x_o), 12'd0);
    chk("reset_y", 12'(bullet_y_o), 12'd0);
    chk("colour", {bullet_red_o, bullet_green_o, bullet_blue_o}, 12'h0F0);

    // Launch and flight to the top border
    push_ev(1'b1, 10'd267, 10'd440);
    shoot_i = 1'b1;
    cyc();
    shoot_i = 1'b0;
    chk("launch_y", 12'(bullet_y_o), 12'd440);
    cyc();
    chk("fired_one_cycle", 12'(fired_o), 12'd0);
    repeat (108) tick();
    chk("top_y", 12'(bullet_y_o), 12'd8);
    chk("top_active", 12'(active_o), 12'd1);
    push_ev(1'b0, 10'd267, 10'd8);
    tick();
    chk("retire_active", 12'(active_o), 12'd0);
    chk("retire_y_hold", 12'(bullet_y_o), 12'd8);

    // Held button through a full flight: exactly one launch
    pos_left_i = 10'd100;
    push_ev(1'b1, 10'd117, 10'd440);
    shoot_i = 1'b1;
    cyc();
    push_ev(1'b0, 10'd117, 10'd8);
    for (int i = 0; i < 1000; i++) begin
      frame_tick_i = (i % 2 == 0);
      cyc();
    end
    frame_tick_i = 1'b0;
    shoot_i = 1'b0;
    cyc();
    chk("hold_inactive", 12'(active_o), 12'd0);

    // Collision racing a frame tick at y=200
    pos_left_i = 10'd300;
    push_ev(1'b1, 10'd317, 10'd440);
    shoot_i = 1'b1;
    cyc();
    shoot_i = 1'b0;
    repeat (60) tick();
    chk("pre_collide_y", 12'(bullet_y_o), 12'd200);
    pos_left_i = 10'd10;
    push_ev(1'b0, 10'd317, 10'd200);
    frame_tick_i = 1'b1;
    collide_i = 1'b1;
    cyc();
    frame_tick_i = 1'b0;
    collide_i = 1'b0;
    chk("collide_active", 12'(active_o), 12'd0);
    chk("collide_y", 12'(bullet_y_o), 12'd200);

`ifdef PLAYER_BULLET_COOLDOWN_EN
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
`endif
    push_ev(1'b1, 10'd27, 10'd440);
    shoot_i = 1'b1;
    cyc();
    chk("refire_fired", 12'(fired_o), 12'd1);
    shoot_i = 1'b0;

    // Freeze holds position; death cancels and blocks firing
    repeat (10) tick();
    chk("pre_freeze_y", 12'(bullet_y_o), 12'd400);
    freeze_i = 1'b1;
    repeat (5) tick();
    chk("freeze_y", 12'(bullet_y_o), 12'd400);
    chk("freeze_active", 12'(active_o), 12'd1);
    push_ev(1'b0, 10'd27, 10'd400);
    alive_i = 1'b0;
    cyc();
    chk("death_active", 12'(active_o), 12'd0);
    freeze_i = 1'b0;
    cyc();
    shoot_i = 1'b1;
    cyc();
    cyc();
    chk("dead_no_fire", 12'(fired_o), 12'd0);
    chk("dead_inactive", 12'(active_o), 12'd0);
    shoot_i = 1'b0;
    alive_i = 1'b1;
    cyc();

`ifdef PLAYER_BULLET_COOLDOWN_EN
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    pos_left_i = 10'd50;
    push_ev(1'b1, 10'd67, 10'd440);
    shoot_i = 1'b1;
    cyc();
    shoot_i = 1'b0;
    push_ev(1'b0, 10'd67, 10'd440);
    collide_i = 1'b1;
    cyc();
    collide_i = 1'b0;
    repeat (7) tick();
    shoot_i = 1'b1;
    cyc();
    cyc();
    chk("cd_early_no_fire", 12'(fired_o), 12'd0);
    shoot_i = 1'b0;
    cyc();
    tick();
    cyc();
    push_ev(1'b1, 10'd67, 10'd440);
    shoot_i = 1'b1;
    cyc();
    chk("cd_done_fire", 12'(fired_o), 12'd1);
    shoot_i = 1'b0;
`endif

    repeat (4) cyc();
    chk("events_pending", 12'(exp_q.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
